jtkicker_dwnld_ctrl: RTL

Sequences the ROM download stream into SDRAM and PROM writes for the Kicker-family game cores. It classifies each ioctl byte by region and applies the per-region address swizzle (scroll and object layout). It then issues SDRAM writes with a prog_we/prog_rdy handshake and a one-entry skid buffer, or pulses prom_we for PROM bytes. It sits between the framework download port and the SDRAM/PROM write ports of the game top level.

---
 rtl/jtkicker_dwnld_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/jtkicker_dwnld_ctrl.sv
// ROM download sequencer for the Kicker-family cores.
// Splits the ioctl byte stream into SDRAM writes (with region address
// swizzle, prog_we/prog_rdy handshake and a one-entry skid buffer) and
// single-cycle PROM write strobes.
module jtkicker_dwnld_ctrl #(
  parameter logic [21:0] SND_START  = 22'h0,
  parameter logic [21:0] SCR_START  = 22'h0,
  parameter logic [21:0] OBJ_START  = 22'h0,
  parameter logic [21:0] PCM_START  = 22'h0,
  parameter logic [24:0] PROM_START = 25'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic [10:0] prom_addr,
  output logic [7:0]  prom_data,
  output logic        prom_we,
  output logic        dwnld_busy,
  output logic        overflow
);

  // The region map must be ascending; the sound region start only bounds
  // the layout, it needs no address treatment of its own.
  if (SND_START > SCR_START || SCR_START > OBJ_START || OBJ_START > PCM_START) begin : g_bad_layout
    $error("jtkicker_dwnld_ctrl: ROM region starts must be in ascending order");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GAP} state_t;

  state_t      state_q, state_d;
  logic [21:0] prog_addr_q, prog_addr_d;
  logic [7:0]  prog_data_q, prog_data_d;
  logic        buf_valid_q, buf_valid_d;
  logic [21:0] buf_addr_q, buf_addr_d;
  logic [7:0]  buf_data_q, buf_data_d;
  logic        overflow_q, overflow_d;
  logic        busy_q, busy_d;
  logic        prom_we_q, prom_we_d;
  logic [10:0] prom_addr_q, prom_addr_d;
  logic [7:0]  prom_data_q, prom_data_d;

  logic [21:0] byte_addr;
  logic [21:0] swz_addr;
  logic [10:0] prom_off;
  logic        in_scr, in_obj, in_prom;
  logic        wr_ok, sdram_wr;
  logic        pop, direct;

  assign byte_addr = ioctl_addr[21:0];
  assign in_prom   = ioctl_addr >= PROM_START;
  assign in_scr    = (byte_addr >= SCR_START) && (byte_addr < OBJ_START);
  assign in_obj    = (byte_addr >= OBJ_START) && (byte_addr < PCM_START);
  assign prom_off  = ioctl_addr[10:0] - PROM_START[10:0];
  assign wr_ok     = ioctl_wr & downloading;
  assign sdram_wr  = wr_ok & ~in_prom;

  // Region-dependent address swizzle for the scroll and object layouts.
  always_comb begin
    swz_addr = byte_addr;
    if (in_scr) begin
      swz_addr[0] = ~byte_addr[0];
    end else if (in_obj) begin
      swz_addr[4:0] = {byte_addr[2:0], ~byte_addr[4], ~byte_addr[3]};
    end
  end

  // SDRAM write sequencer: IDLE -> WAIT (hold until ack) -> GAP (one dead
  // cycle), plus skid-buffer fill/pop and sticky overflow on a full buffer.
  always_comb begin
    state_d     = state_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    overflow_d  = overflow_q;
    pop         = 1'b0;
    direct      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (buf_valid_q) begin
          pop         = 1'b1;
          prog_addr_d = buf_addr_q;
          prog_data_d = buf_data_q;
          state_d     = ST_WAIT;
        end else if (sdram_wr) begin
          direct      = 1'b1;
          prog_addr_d = swz_addr;
          prog_data_d = ioctl_dout;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (prog_rdy) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (buf_valid_q) begin
          pop         = 1'b1;
          prog_addr_d = buf_addr_q;
          prog_data_d = buf_data_q;
          state_d     = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      buf_valid_d = 1'b0;
    end
    // A pop in the same cycle frees the slot for the incoming byte.
    if (sdram_wr && !direct) begin
      if (!buf_valid_q || pop) begin
        buf_valid_d = 1'b1;
        buf_addr_d  = swz_addr;
        buf_data_d  = ioctl_dout;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // Busy from the first accepted byte until the download ended and drained.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d = 1'b1;
    end else if (!downloading && state_q == ST_IDLE && !buf_valid_q) begin
      busy_d = 1'b0;
    end
  end

  // PROM bytes bypass the SDRAM path and produce a one-cycle strobe.
  always_comb begin
    prom_we_d   = wr_ok & in_prom;
    prom_addr_d = prom_addr_q;
    prom_data_d = prom_data_q;
    if (prom_we_d) begin
      prom_addr_d = prom_off;
      prom_data_d = ioctl_dout;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      prom_we_q   <= 1'b0;
      prom_addr_q <= '0;
      prom_data_q <= '0;
    end else begin
      state_q     <= state_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      prom_we_q   <= prom_we_d;
      prom_addr_q <= prom_addr_d;
      prom_data_q <= prom_data_d;
    end
  end

  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign prog_we    = (state_q == ST_WAIT);
  assign prom_addr  = prom_addr_q;
  assign prom_data  = prom_data_q;
  assign prom_we    = prom_we_q;
  assign dwnld_busy = busy_q;
  assign overflow   = overflow_q;

endmodule
